mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 13 +
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM pipeline stage and the data memory.
// The stage drives the request side; the memory answers with ready and read data.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register plus a two-state data-memory access controller.
// The controller stretches the stage through memory wait states and flags misaligned word accesses.
module mem_access_stage #(
  parameter logic [2:0] LOAD_SEL = 3'b001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       RegWriteE,
  input  logic                       MemWriteE,
  input  logic                       jumpE,
  input  logic [2:0]                 MemtoRegE,
  input  logic [4:0]                 WriteRegE,
  input  logic [31:0]                ALUMultOutE,
  input  logic [31:0]                WriteDataE,
  input  logic [31:0]                PCPlus4E,
  input  logic                       StallM,
  input  logic                       FlushM,
  output logic                       RegWriteM,
  output logic                       jumpM,
  output logic [2:0]                 MemtoRegM,
  output logic [4:0]                 WriteRegM,
  output logic [31:0]                ALUOutM,
  output logic [31:0]                PCPlus4M,
  output logic [31:0]                ReadDataM,
  output logic                       MemBusyM,
  output logic                       AlignErrM,
  mem_access_stage_if.master         dmem
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      stateReg, stateNext;
  logic        regWriteReg;
  logic        memWriteReg;
  logic [31:0] writeDataReg;
  logic        doneReg;
  logic        alignSeenReg;

  logic        isLoadSel;
  logic        isLoad;
  logic        accessValid;
  logic        misaligned;
  logic        reqInt;
  logic        complete;
  logic        hold;

  // A store wins if the decoder ever sets both store and word-load select.
  always_comb begin
    isLoadSel   = (MemtoRegM == LOAD_SEL);
    isLoad      = isLoadSel & ~memWriteReg;
    accessValid = (memWriteReg | isLoadSel) & ~doneReg;
    misaligned  = accessValid & (ALUOutM[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    reqInt    = 1'b0;
    case (stateReg)
      IDLE: begin
        reqInt = accessValid & ~misaligned;
        if (reqInt && !dmem.ready) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        reqInt = 1'b1;
        if (dmem.ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign complete   = reqInt & dmem.ready;
  assign MemBusyM   = reqInt & ~dmem.ready;
  assign hold       = StallM | MemBusyM;

  assign dmem.req   = reqInt;
  assign dmem.we    = reqInt & memWriteReg;
  assign dmem.addr  = ALUOutM;
  assign dmem.wdata = writeDataReg;

  assign AlignErrM  = misaligned;
  // A faulting instruction must not write back, even while it sits stalled in M.
  assign RegWriteM  = regWriteReg & ~misaligned & ~alignSeenReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteReg  <= 1'b0;
      memWriteReg  <= 1'b0;
      jumpM        <= 1'b0;
      MemtoRegM    <= 3'd0;
      WriteRegM    <= 5'd0;
      ALUOutM      <= 32'd0;
      writeDataReg <= 32'd0;
      PCPlus4M     <= 32'd0;
      ReadDataM    <= 32'd0;
      doneReg      <= 1'b0;
      alignSeenReg <= 1'b0;
    end else begin
      if (!hold) begin
        if (FlushM) begin
          regWriteReg  <= 1'b0;
          memWriteReg  <= 1'b0;
          jumpM        <= 1'b0;
          MemtoRegM    <= 3'd0;
          WriteRegM    <= 5'd0;
          ALUOutM      <= 32'd0;
          writeDataReg <= 32'd0;
          PCPlus4M     <= 32'd0;
        end else begin
          regWriteReg  <= RegWriteE;
          memWriteReg  <= MemWriteE;
          jumpM        <= jumpE;
          MemtoRegM    <= MemtoRegE;
          WriteRegM    <= WriteRegE;
          ALUOutM      <= ALUMultOutE;
          writeDataReg <= WriteDataE;
          PCPlus4M     <= PCPlus4E;
        end
      end
      // Progress flags belong to the instruction in M and die when it leaves.
      doneReg      <= hold & (doneReg | complete | misaligned);
      alignSeenReg <= hold & (alignSeenReg | misaligned);
      if (complete && isLoad) begin
        ReadDataM <= dmem.rdata;
      end
    end
  end

endmodule
